// File: rtl/wide_add_sequencer.sv
// Wide add/subtract built from one W-bit slice plus a carry register.
// Ports: CLK/RST, in_valid/in_ready + op_a/op_b/sub in, out_valid/out_ready + sum/carry_out/ovf out, busy.
module wide_add_sequencer #(
  parameter int W     = 32,
  parameter int WORDS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*W-1:0] op_a,
  input  logic [WORDS*W-1:0] op_b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*W-1:0] sum,
  output logic               carry_out,
  output logic               ovf,
  output logic               busy
);

  localparam int TW = WORDS * W;
  localparam int KW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            c_q, c_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic            sub_q, sub_d;
  logic [TW-1:0]   sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    a_w;
  logic [W-1:0]    b_w;
  logic [W-1:0]    bx;
  logic [W:0]      sl;
  logic            top_cin;

  // Current word of each operand; constant indices keep the
  // part selects simple.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k_q == KW'(i)) begin
        a_w = a_q[i*W +: W];
        b_w = b_q[i*W +: W];
      end
    end
  end

  assign bx = b_w ^ {W{sub_q}};
  assign sl = {1'b0, a_w} + {1'b0, bx} + {{W{1'b0}}, c_q};
  // Carry into the slice MSB, recovered from its sum bit.
  assign top_cin = sl[W-1] ^ a_w[W-1] ^ bx[W-1];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          c_d     = sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d = sl[W];
        for (int i = 0; i < WORDS; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[i*W +: W] = sl[W-1:0];
          end
        end
        if (k_q == KW'(WORDS - 1)) begin
          cout_d  = sl[W];
          ovf_d   = top_cin ^ sl[W];
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed corner cases plus
// randomized traffic checked against a whole-width arithmetic model.
module tb_wide_add_sequencer;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int TW    = W * WORDS;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] op_a = '0;
  logic [TW-1:0] op_b = '0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] sum;
  logic          carry_out;
  logic          ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(.W(W), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .ovf(ovf), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [TW-1:0] act,
                     input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Whole-width reference: {ovf, carry, result}.
  function automatic logic [TW+1:0] ref_fn(input logic [TW-1:0] a,
                                           input logic [TW-1:0] b,
                                           input logic s);
    logic [TW:0]   f;
    logic [TW-1:0] r;
    logic          o;
    if (s) f = {1'b0, a} + {1'b0, ~b} + (TW+1)'(1);
    else   f = {1'b0, a} + {1'b0, b};
    r = f[TW-1:0];
    if (s) o = (a[TW-1] != b[TW-1]) && (r[TW-1] != a[TW-1]);
    else   o = (a[TW-1] == b[TW-1]) && (r[TW-1] != a[TW-1]);
    return {o, f[TW], r};
  endfunction

  function automatic logic [TW-1:0] rnd();
    logic [TW-1:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [TW-1:0] pick();
    logic [TW-1:0] r;
    case ($urandom_range(0, 5))
      0: r = '0;
      1: r = '1;
      2: r = {1'b0, {(TW-1){1'b1}}};
      3: r = {1'b1, {(TW-1){1'b0}}};
      default: r = rnd();
    endcase
    return r;
  endfunction

  // Model: phase 0 = waiting for operands, 1..WORDS = computing,
  // WORDS+1 = result offered.
  int            phase = 0;
  int            cyc = 0;
  int            acc_n = 0;
  int            acc_cyc[$];
  logic [TW+1:0] pend = '0;
  logic [TW+1:0] m_out = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= 0;
      m_out <= '0;
    end else begin
      cyc <= cyc + 1;
      if (phase == 0) begin
        if (in_valid) begin
          pend  <= ref_fn(op_a, op_b, sub);
          phase <= 1;
          acc_n <= acc_n + 1;
          acc_cyc.push_back(cyc);
        end
      end else if (phase < WORDS) begin
        phase <= phase + 1;
      end else if (phase == WORDS) begin
        phase <= WORDS + 1;
        m_out <= pend;
      end else if (out_ready) begin
        phase <= 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("in_ready", TW'(in_ready), TW'(phase == 0));
      chk("out_valid", TW'(out_valid), TW'(phase == WORDS + 1));
      chk("busy", TW'(busy), TW'(phase != 0));
      if (phase == WORDS + 1) begin
        chk("sum", sum, m_out[TW-1:0]);
        chk("carry_out", TW'(carry_out), TW'(m_out[TW]));
        chk("ovf", TW'(ovf), TW'(m_out[TW+1]));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL wait_idle: got timeout expected in_ready");
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_txn(input string nm, input logic [TW-1:0] a,
                         input logic [TW-1:0] b, input logic s,
                         input logic [TW-1:0] es, input logic ec,
                         input logic eo);
    int n;
    wait_idle();
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub = s;
    step();
    in_valid = 1'b0;
    op_a = rnd();
    op_b = rnd();
    sub = ~s;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, TW'(n), TW'(WORDS));
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, TW'(carry_out), TW'(ec));
    chk({nm, "_ovf"}, TW'(ovf), TW'(eo));
    chk({nm, "_model"}, m_out, {eo, ec, es});
  endtask

  initial begin
    logic [TW-1:0] ones;
    logic [TW-1:0] smax;
    logic [TW-1:0] smin;
    logic [TW-1:0] one;
    logic [TW-1:0] hold_s;
    logic          hold_c;
    logic          hold_o;
    logic [TW-1:0] sets[3];
    int            base;
    int            n;
    ones = '1;
    smax = {1'b0, {(TW-1){1'b1}}};
    smin = {1'b1, {(TW-1){1'b0}}};
    one = TW'(1);

    #1;
    chk("rst_sum", sum, '0);
    chk("rst_flags", TW'({carry_out, ovf, out_valid, busy}), '0);
    chk("rst_in_ready", TW'(in_ready), TW'(1));
    step();
    step();
    RST = 1'b0;
    step();

    run_txn("ripple", 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
            one, 1'b0, 128'h0000_0001_0000_0000_0000_0000_0000_0000,
            1'b0, 1'b0);
    release_out();
    run_txn("wrap", ones, one, 1'b0, '0, 1'b1, 1'b0);
    release_out();
    run_txn("smax_inc", smax, one, 1'b0, smin, 1'b0, 1'b1);
    release_out();
    run_txn("zero_dec", '0, one, 1'b1, ones, 1'b0, 1'b0);
    release_out();
    run_txn("smin_dec", smin, one, 1'b1, smax, 1'b1, 1'b1);

    // Backpressure: result must hold while inputs churn.
    hold_s = sum;
    hold_c = carry_out;
    hold_o = ovf;
    base = acc_n;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a = rnd();
      op_b = rnd();
      sub = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    chk("bp_sum", sum, hold_s);
    chk("bp_flags", TW'({carry_out, ovf}), TW'({hold_c, hold_o}));
    chk("bp_no_capture", TW'(acc_n - base), '0);
    release_out();
    chk("bp_idle", TW'(in_ready), TW'(1));

    // Reset in the middle of a run.
    in_valid = 1'b1;
    op_a = rnd();
    op_b = rnd();
    step();
    in_valid = 1'b0;
    step();
    step();
    RST = 1'b1;
    #1;
    chk("mid_rst_sum", sum, '0);
    chk("mid_rst_flags",
        TW'({carry_out, ovf, out_valid, busy}), '0);
    chk("mid_rst_in_ready", TW'(in_ready), TW'(1));
    step();
    RST = 1'b0;
    step();
    run_txn("post_rst", 128'h1, 128'h2, 1'b1, ones, 1'b0, 1'b0);
    release_out();

    // Back-to-back with both handshakes held high.
    sets[0] = rnd();
    sets[1] = rnd();
    sets[2] = rnd();
    base = acc_cyc.size();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int start;
      op_a = sets[i];
      op_b = sets[(i + 1) % 3];
      sub = 1'(i);
      start = acc_n;
      n = 0;
      while (acc_n == start && n < 50) begin
        step();
        n++;
      end
      chk("b2b_accept", TW'(acc_n - start), TW'(1));
    end
    in_valid = 1'b0;
    wait_idle();
    out_ready = 1'b0;
    if (acc_cyc.size() >= base + 3) begin
      chk("b2b_gap1", TW'(acc_cyc[base+1] - acc_cyc[base]),
          TW'(WORDS + 2));
      chk("b2b_gap2", TW'(acc_cyc[base+2] - acc_cyc[base+1]),
          TW'(WORDS + 2));
    end else begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d",
               acc_cyc.size() - base, 3);
    end

    // Randomized traffic with random backpressure.
    for (int t = 0; t < 40; t++) begin
      int start;
      wait_idle();
      op_a = pick();
      op_b = pick();
      sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      start = acc_n;
      step();
      in_valid = 1'($urandom_range(0, 1));
      chk("rnd_accept", TW'(acc_n - start), TW'(1));
      n = 0;
      while (!in_ready && n < 60) begin
        out_ready = 1'($urandom_range(0, 1));
        op_a = rnd();
        in_valid = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
    end
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle wide adder/subtractor controller. It performs one WORDS*W-bit add or subtract by sequencing a single W-bit adder slice with a carry register, one word per cycle, LSB word first. It sits between an upstream operand producer and a downstream result consumer, with valid/ready handshakes on both sides. Only one transaction is in flight at a time.

Parameters:
W, 32, width of the internal adder slice in bits
WORDS, 4, number of slices per operand (total width WORDS*W, 128 by default); must be >= 2

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
in_valid  input  1  operand transaction offered
in_ready  output  1  block can accept operands
op_a  input  WORDS*W  operand A, unsigned/two's complement
op_b  input  WORDS*W  operand B
sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WORDS*W  result
carry_out  output  1  final carry (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous and active-high. While RST is high: state IDLE, word counter 0, carry register 0, captured operands 0, sum 0, carry_out 0, ovf 0, out_valid 0, busy 0. No handshake is taken on any edge where RST is high.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, busy=1.
  - DONE: in_ready=0, out_valid=1, busy=1.
- in_ready is exactly (state==IDLE). out_valid is exactly (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- IDLE, on an edge with in_valid=1: capture op_a, op_b and sub. Set carry register = sub, counter k = 0, go to RUN.
- RUN, each edge:
  - {c, r} = A[k] + (B[k] XOR {W{sub}}) + carry, computed at W+1 bits with no truncation before the carry.
  - Write r into sum[k*W +: W]. Carry register <= c.
  - On k == WORDS-1: carry_out <= c; ovf <= carry into the top bit XOR c; go to DONE. Otherwise k <= k+1.
- sum words not yet written in the current transaction hold their previous values. Consumers read sum only when out_valid=1.
- DONE: sum, carry_out and ovf are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE. Outputs keep their values until the next transaction overwrites them.
- Latency: accept on edge e0 gives out_valid=1 after edge e0+WORDS. The earliest next accept is edge e0+WORDS+2 (one DONE edge, one IDLE edge). Sustained period is WORDS+2 cycles.
- in_valid, op_a, op_b and sub are ignored outside IDLE. Operand changes after capture do not affect the result.
- Wrap-around: arithmetic is modulo 2^(WORDS*W). Overflow is reported only via carry_out and ovf.
- Reset mid-RUN or mid-DONE aborts the transaction. The result is discarded and no out_valid pulse is produced.
- No simultaneous accept and output: IDLE and DONE are exclusive, so input and output handshakes never coincide.

Test Plan:
- Carry ripple (W=32, WORDS=4): a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=128'h0000_0001_0000_0000_0000_0000_0000_0000, carry_out=0, ovf=0. out_valid rises exactly 4 edges after the accept edge.
- Full wrap: a=all ones, b=1, sub=0 -> sum=0, carry_out=1, ovf=0. Then a=128'h7FFF..FF, b=1 -> sum=128'h8000..00, carry_out=0, ovf=1.
- Subtract: a=0, b=1, sub=1 -> sum=all ones, carry_out=0, ovf=0. Then a=128'h8000..00, b=1, sub=1 -> sum=128'h7FFF..FF, carry_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, and toggle in_valid and operands throughout. Required: sum, carry_out and ovf unchanged; in_ready=0; no new capture. Raising out_ready then gives IDLE on the next edge.
- Reset mid-RUN: assert RST after 2 RUN edges. Required: all outputs 0 immediately (asynchronous), in_ready=1, no out_valid. A fresh transaction after release produces the correct result.
- Back-to-back: out_ready=1 and in_valid=1 held with 3 distinct operand sets. Required: accepts spaced exactly 6 cycles apart, results in order and correct, busy low only on the IDLE cycles.
